// File: rtl/fht_addr_gen.sv
// Operand/write-back address sequencer for a ping-pong radix-2 FHT.
// One butterfly is issued per cycle; write-back addresses follow through a D-deep delay pipe.
module fht_addr_gen #(
  parameter int LOG2N   = 8,
  parameter int RD_LAT  = 1,
  parameter int BUT_LAT = 2
) (
  input  logic             iCLK,
  input  logic             iRESET,
  input  logic             iSTART,
  output logic             oBUSY,
  output logic             oDONE,
  output logic [3:0]       oSTAGE,
  output logic             oRD_EN,
  output logic             oRD_BANK,
  output logic [LOG2N-1:0] oRD_ADDR_0,
  output logic [LOG2N-1:0] oRD_ADDR_1,
  output logic [LOG2N-1:0] oRD_ADDR_2,
  output logic [LOG2N-2:0] oTW_ADDR,
  output logic             oWR_EN,
  output logic             oWR_BANK,
  output logic [LOG2N-1:0] oWR_ADDR_0,
  output logic [LOG2N-1:0] oWR_ADDR_1,
  output logic             oRES_BANK
);

  localparam int D  = RD_LAT + BUT_LAT;
  localparam int DW = (D > 1) ? $clog2(D) : 1;
  localparam int WW = 2 + 2 * LOG2N;
  localparam logic [LOG2N-2:0] J_LAST     = '1;
  localparam logic [DW-1:0]    DRAIN_LAST = DW'(D - 1);
  localparam logic [3:0]       STAGE_LAST = 4'(LOG2N - 1);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, FIN} state_t;

  state_t           state_q, state_d;
  logic [LOG2N-2:0] j_q, j_d;
  logic [3:0]       stage_q, stage_d;
  logic [DW-1:0]    drain_q, drain_d;

  always_ff @(posedge iCLK) begin
    if (iRESET) begin
      state_q <= IDLE;
      j_q     <= '0;
      stage_q <= '0;
      drain_q <= '0;
    end else begin
      state_q <= state_d;
      j_q     <= j_d;
      stage_q <= stage_d;
      drain_q <= drain_d;
    end
  end

  always_comb begin
    state_d = state_q;
    j_d     = j_q;
    stage_d = stage_q;
    drain_d = drain_q;
    case (state_q)
      IDLE: begin
        if (iSTART) begin
          state_d = RUN;
          j_d     = '0;
          stage_d = '0;
        end
      end
      RUN: begin
        if (j_q == J_LAST) begin
          state_d = DRAIN;
          drain_d = '0;
        end else begin
          j_d = j_q + 1'b1;
        end
      end
      DRAIN: begin
        if (drain_q == DRAIN_LAST) begin
          if (stage_q == STAGE_LAST) begin
            state_d = FIN;
          end else begin
            state_d = RUN;
            stage_d = stage_q + 1'b1;
            j_d     = '0;
          end
        end else begin
          drain_d = drain_q + 1'b1;
        end
      end
      FIN: begin
        state_d = IDLE;
        stage_d = '0;
      end
      default: state_d = IDLE;
    endcase
  end

  // Read-side address math: split j at bit s and open a gap there for the pair bit.
  logic             rd_en;
  logic [LOG2N-1:0] j_ext, h, mask, lo, hi, a0, a1, a2;
  logic [LOG2N-2:0] tw;

  assign rd_en = (state_q == RUN);

  always_comb begin
    j_ext = {1'b0, j_q};
    h     = LOG2N'(1) << stage_q;
    mask  = h - LOG2N'(1);
    lo    = j_ext & mask;
    hi    = (j_ext & ~mask) << 1;
    a0    = hi | lo;
    a1    = hi | h | lo;
    a2    = hi | h | ((~lo + LOG2N'(1)) & mask);
    tw    = lo[LOG2N-2:0] << (STAGE_LAST - stage_q);
    if (!rd_en) begin
      a0 = '0;
      a1 = '0;
      a2 = '0;
      tw = '0;
    end
  end

  // Write-back pipe: {en, bank, addr0, addr1} delayed by exactly D cycles.
  logic [WW-1:0] pipe_in;
  assign pipe_in = {rd_en, rd_en & ~stage_q[0], a0, a1};

  genvar gi;
  generate
    for (gi = 0; gi < D; gi++) begin : g_pipe
      logic [WW-1:0] q;
      always_ff @(posedge iCLK) begin
        if (iRESET) begin
          q <= '0;
        end else if (gi == 0) begin
          q <= pipe_in;
        end else begin
          q <= g_pipe[(gi > 0) ? gi - 1 : 0].q;
        end
      end
    end
  endgenerate

  assign oBUSY      = (state_q != IDLE);
  assign oDONE      = (state_q == FIN);
  assign oSTAGE     = stage_q;
  assign oRD_EN     = rd_en;
  assign oRD_BANK   = stage_q[0];
  assign oRD_ADDR_0 = a0;
  assign oRD_ADDR_1 = a1;
  assign oRD_ADDR_2 = a2;
  assign oTW_ADDR   = tw;
  assign {oWR_EN, oWR_BANK, oWR_ADDR_0, oWR_ADDR_1} = g_pipe[D-1].q;
  assign oRES_BANK  = 1'(LOG2N % 2);

endmodule

// File: tb/tb_fht_addr_gen.sv
// Scoreboard bench for fht_addr_gen: an N=8 instance checked cycle by cycle,
// and an N=256 instance checked for overall timing.
module tb_fht_addr_gen;

  localparam int L  = 3;
  localparam int N  = 8;
  localparam int D  = 3;
  localparam int P  = N / 2 + D;
  localparam int LB = 8;
  localparam int PB = 128 + D;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, start, start_big;

  logic         s_busy, s_done, s_rd_en, s_rd_bank, s_wr_en, s_wr_bank, s_res_bank;
  logic [3:0]   s_stage;
  logic [L-1:0] s_a0, s_a1, s_a2, s_w0, s_w1;
  logic [L-2:0] s_tw;

  logic          b_busy, b_done, b_rd_en, b_rd_bank, b_wr_en, b_wr_bank, b_res_bank;
  logic [3:0]    b_stage;
  logic [LB-1:0] b_a0, b_a1, b_a2, b_w0, b_w1;
  logic [LB-2:0] b_tw;

  fht_addr_gen #(.LOG2N(L), .RD_LAT(1), .BUT_LAT(2)) dut (
    .iCLK(clk), .iRESET(rst), .iSTART(start),
    .oBUSY(s_busy), .oDONE(s_done), .oSTAGE(s_stage),
    .oRD_EN(s_rd_en), .oRD_BANK(s_rd_bank),
    .oRD_ADDR_0(s_a0), .oRD_ADDR_1(s_a1), .oRD_ADDR_2(s_a2), .oTW_ADDR(s_tw),
    .oWR_EN(s_wr_en), .oWR_BANK(s_wr_bank), .oWR_ADDR_0(s_w0), .oWR_ADDR_1(s_w1),
    .oRES_BANK(s_res_bank)
  );

  fht_addr_gen #(.LOG2N(LB), .RD_LAT(1), .BUT_LAT(2)) dut_big (
    .iCLK(clk), .iRESET(rst), .iSTART(start_big),
    .oBUSY(b_busy), .oDONE(b_done), .oSTAGE(b_stage),
    .oRD_EN(b_rd_en), .oRD_BANK(b_rd_bank),
    .oRD_ADDR_0(b_a0), .oRD_ADDR_1(b_a1), .oRD_ADDR_2(b_a2), .oTW_ADDR(b_tw),
    .oWR_EN(b_wr_en), .oWR_BANK(b_wr_bank), .oWR_ADDR_0(b_w0), .oWR_ADDR_1(b_w1),
    .oRES_BANK(b_res_bank)
  );

  int checks   = 0;
  int failures = 0;

  typedef struct {int cyc; int a0; int a1; int a2; int tw; int bank; int stage;} rd_t;
  typedef struct {int cyc; int a0; int a1; int bank;} wr_t;
  rd_t rd_q[$];
  wr_t wr_q[$];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference model: integer arithmetic on the butterfly index.
  task automatic push_expected();
    rd_t r;
    wr_t w;
    rd_q.delete();
    wr_q.delete();
    for (int s = 0; s < L; s++) begin
      for (int j = 0; j < N / 2; j++) begin
        int h, k, hi;
        h       = 1 << s;
        k       = j % h;
        hi      = j / h;
        r.cyc   = 1 + s * P + j;
        r.a0    = hi * 2 * h + k;
        r.a1    = hi * 2 * h + h + k;
        r.a2    = hi * 2 * h + h + ((h - k) % h);
        r.tw    = k * ((N / 2) / h);
        r.bank  = s % 2;
        r.stage = s;
        rd_q.push_back(r);
        w.cyc  = r.cyc + D;
        w.a0   = r.a0;
        w.a1   = r.a1;
        w.bank = 1 - (s % 2);
        wr_q.push_back(w);
      end
    end
  endtask

  // Full N=8 run starting in the current cycle; extra iSTART pulses at cycles x1/x2.
  task automatic run_transform(input int x1, input int x2, input string tag);
    int done_cyc;
    bit exp_rd, exp_wr;
    rd_t e;
    wr_t w;
    done_cyc = L * P + 1;
    push_expected();
    start = 1'b1;
    for (int c = 1; c <= done_cyc + 1; c++) begin
      step();
      start = (c == x1) || (c == x2);
      exp_rd = (rd_q.size() > 0) && (rd_q[0].cyc == c);
      checks++;
      if (s_rd_en !== exp_rd) begin
        failures++;
        $display("FAIL %s rd_en cyc=%0d got=%b required=%b", tag, c, s_rd_en, exp_rd);
      end
      if (exp_rd) begin
        e = rd_q.pop_front();
        if (s_rd_en === 1'b1) begin
          $display("RD  %s cyc=%0d stage=%0d a=(%0d,%0d,%0d) tw=%0d bank=%0d",
                   tag, c, s_stage, s_a0, s_a1, s_a2, s_tw, s_rd_bank);
          checks++;
          if (s_a0 !== L'(e.a0) || s_a1 !== L'(e.a1) || s_a2 !== L'(e.a2) ||
              s_tw !== (L-1)'(e.tw) || s_rd_bank !== 1'(e.bank) || s_stage !== 4'(e.stage)) begin
            failures++;
            $display("FAIL %s rd_fields cyc=%0d got=(%0d,%0d,%0d,%0d,b%0d,s%0d) required=(%0d,%0d,%0d,%0d,b%0d,s%0d)",
                     tag, c, s_a0, s_a1, s_a2, s_tw, s_rd_bank, s_stage,
                     e.a0, e.a1, e.a2, e.tw, e.bank, e.stage);
          end
        end
      end
      exp_wr = (wr_q.size() > 0) && (wr_q[0].cyc == c);
      checks++;
      if (s_wr_en !== exp_wr) begin
        failures++;
        $display("FAIL %s wr_en cyc=%0d got=%b required=%b", tag, c, s_wr_en, exp_wr);
      end
      if (exp_wr) begin
        w = wr_q.pop_front();
        if (s_wr_en === 1'b1) begin
          $display("WR  %s cyc=%0d a=(%0d,%0d) bank=%0d", tag, c, s_w0, s_w1, s_wr_bank);
          checks++;
          if (s_w0 !== L'(w.a0) || s_w1 !== L'(w.a1) || s_wr_bank !== 1'(w.bank)) begin
            failures++;
            $display("FAIL %s wr_fields cyc=%0d got=(%0d,%0d,b%0d) required=(%0d,%0d,b%0d)",
                     tag, c, s_w0, s_w1, s_wr_bank, w.a0, w.a1, w.bank);
          end
        end
      end
      checks++;
      if (s_done !== (c == done_cyc) || s_busy !== (c <= done_cyc)) begin
        failures++;
        $display("FAIL %s done_busy cyc=%0d got=(%b,%b) required=(%b,%b)",
                 tag, c, s_done, s_busy, (c == done_cyc), (c <= done_cyc));
      end
      if (c == done_cyc) $display("DONE %s cyc=%0d", tag, c);
    end
    checks++;
    if (rd_q.size() != 0 || wr_q.size() != 0 || s_res_bank !== 1'b1) begin
      failures++;
      $display("FAIL %s leftover got=(rd%0d,wr%0d,res%b) required=(rd0,wr0,res1)",
               tag, rd_q.size(), wr_q.size(), s_res_bank);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    start = 1'b1;
    start_big = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      checks++;
      if ({s_busy, s_done, s_stage, s_rd_en, s_rd_bank, s_a0, s_a1, s_a2, s_tw,
           s_wr_en, s_wr_bank, s_w0, s_w1} !== '0 || s_res_bank !== 1'b1) begin
        failures++;
        $display("FAIL reset_small cyc=%0d got=%h res=%b required=0 res=1", i,
                 {s_busy, s_done, s_stage, s_rd_en, s_rd_bank, s_a0, s_a1, s_a2, s_tw,
                  s_wr_en, s_wr_bank, s_w0, s_w1}, s_res_bank);
      end
      checks++;
      if ({b_busy, b_done, b_stage, b_rd_en, b_rd_bank, b_a0, b_a1, b_a2, b_tw,
           b_wr_en, b_wr_bank, b_w0, b_w1} !== '0 || b_res_bank !== 1'b0) begin
        failures++;
        $display("FAIL reset_big cyc=%0d got=%h res=%b required=0 res=0", i,
                 {b_busy, b_done, b_stage, b_rd_en, b_rd_bank, b_a0, b_a1, b_a2, b_tw,
                  b_wr_en, b_wr_bank, b_w0, b_w1}, b_res_bank);
      end
    end
    rst = 1'b0;
    start = 1'b0;
    start_big = 1'b0;
    step();
    checks++;
    if (s_busy !== 1'b0 || b_busy !== 1'b0) begin
      failures++;
      $display("FAIL reset_release busy got=(%b,%b) required=(0,0)", s_busy, b_busy);
    end
    $display("RESET checked");
  endtask

  task automatic test_reset_mid_op();
    start = 1'b1;
    for (int c = 1; c <= 12; c++) begin
      step();
      start = 1'b0;
      if (c == 9) begin
        checks++;
        if (s_rd_en !== 1'b1 || s_busy !== 1'b1) begin
          failures++;
          $display("FAIL midop_running cyc=9 got=(%b,%b) required=(1,1)", s_rd_en, s_busy);
        end
      end
      if (c == 10) rst = 1'b1;
      if (c >= 11) begin
        rst = 1'b0;
        checks++;
        if ({s_busy, s_done, s_stage, s_rd_en, s_rd_bank, s_a0, s_a1, s_a2, s_tw,
             s_wr_en, s_wr_bank, s_w0, s_w1} !== '0) begin
          failures++;
          $display("FAIL midop_cleared cyc=%0d got=%h required=0", c,
                   {s_busy, s_done, s_stage, s_rd_en, s_rd_bank, s_a0, s_a1, s_a2, s_tw,
                    s_wr_en, s_wr_bank, s_w0, s_w1});
        end
      end
    end
    $display("MIDOP reset checked, restarting at cycle 12");
    run_transform(0, 0, "post_reset");
  endtask

  task automatic test_n256();
    int rd_count;
    int done_cyc;
    done_cyc = LB * PB + 1;
    rd_count = 0;
    start_big = 1'b1;
    for (int c = 1; c <= done_cyc + 1; c++) begin
      step();
      start_big = 1'b0;
      if (b_rd_en === 1'b1) rd_count++;
      if (c == 1) begin
        checks++;
        if (b_rd_en !== 1'b1 || b_a0 !== 8'd0 || b_a1 !== 8'd1 || b_a2 !== 8'd1 || b_tw !== 7'd0) begin
          failures++;
          $display("FAIL n256_first got=(%b,%0d,%0d,%0d,%0d) required=(1,0,1,1,0)",
                   b_rd_en, b_a0, b_a1, b_a2, b_tw);
        end
      end
      checks++;
      if (b_done !== (c == done_cyc) || b_busy !== (c <= done_cyc)) begin
        failures++;
        $display("FAIL n256_done_busy cyc=%0d got=(%b,%b) required=(%b,%b)",
                 c, b_done, b_busy, (c == done_cyc), (c <= done_cyc));
      end
    end
    checks++;
    if (rd_count != LB * 128) begin
      failures++;
      $display("FAIL n256_reads got=%0d required=%0d", rd_count, LB * 128);
    end
    $display("N256 done_cycle=%0d reads=%0d", done_cyc, rd_count);
  endtask

  initial begin
    rst = 1'b1;
    start = 1'b0;
    start_big = 1'b0;
    test_reset();
    run_transform(0, 0, "single");
    run_transform(5, 20, "busy_start");
    run_transform(22, 0, "start_in_done");
    test_reset_mid_op();
    test_n256();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
